// File: rtl/aes_pnm_pkg.sv
// Shared types and constants for the FeRAM near-memory AES job scheduler.
package aes_pnm_pkg;

  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned RK_IDX_W   = 4;
  localparam int unsigned INIT_BEATS = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRel,
    StStart,
    StRun,
    StOut
  } sched_state_e;

  // Byte offset of key byte (row r, column c) inside a 128-bit round key.
  function automatic int unsigned key_byte_idx(input int unsigned r, input int unsigned c);
    return 4 * r + c;
  endfunction

endpackage

// File: rtl/aes_pnm_rk_table.sv
// Round-key table: flop array with one write port, one combinational read port and a
// registered drop pulse for writes that arrive while busy or with an out-of-range index.
module aes_pnm_rk_table
  import aes_pnm_pkg::*;
#(
  parameter int unsigned N_ROUNDS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_allow_i,
  input  logic                wr_en_i,
  input  logic [RK_IDX_W-1:0] wr_idx_i,
  input  logic [BLOCK_W-1:0]  wr_data_i,
  input  logic [RK_IDX_W-1:0] rd_idx_i,
  output logic [BLOCK_W-1:0]  rd_data_o,
  output logic                wr_drop_o
);

  localparam int unsigned NUM_KEYS = N_ROUNDS + 1;

  logic [BLOCK_W-1:0] keys_q [NUM_KEYS];
  logic               wr_ok;
  logic               drop_q;

  assign wr_ok = wr_allow_i && (wr_idx_i <= RK_IDX_W'(N_ROUNDS));

  // Key storage is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (wr_en_i && wr_ok) begin
      keys_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else begin
      drop_q <= wr_en_i && !wr_ok;
    end
  end

  assign rd_data_o = keys_q[rd_idx_i];
  assign wr_drop_o = drop_q;

endmodule

// File: rtl/aes_pnm_job_sched.sv
// Job scheduler in front of the near-memory AES core: accepts a block, sequences the core
// through init-load, release, start and run, then returns the result or a timeout error.
module aes_pnm_job_sched
  import aes_pnm_pkg::*;
#(
  parameter int unsigned N_ROUNDS    = 10,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BLOCK_W-1:0]  in_block,
  input  logic                in_enc_dec,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                rk_wr_en,
  input  logic [RK_IDX_W-1:0] rk_wr_idx,
  input  logic [BLOCK_W-1:0]  rk_wr_data,
  output logic                rk_wr_drop,
  output logic                core_start,
  output logic                core_enc_dec,
  output logic [BLOCK_W-1:0]  core_state_init,
  output logic                core_state_init_en,
  output logic [BLOCK_W-1:0]  core_key,
  input  logic                core_done,
  input  logic [RK_IDX_W-1:0] core_round,
  input  logic [BLOCK_W-1:0]  core_state_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BLOCK_W-1:0]  out_block,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_err,
  output logic                busy
);

  localparam int unsigned          TMO_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [RK_IDX_W-1:0]  LAST_IDX  = RK_IDX_W'(N_ROUNDS);
  localparam logic [TMO_W-1:0]     TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]           BEAT_LAST = 2'(INIT_BEATS - 1);

  sched_state_e        state_q, state_d;
  logic [1:0]          beat_q, beat_d;
  logic [BLOCK_W-1:0]  blk_q, blk_d;
  logic                enc_q, enc_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [BLOCK_W-1:0]  res_q, res_d;
  logic                err_q, err_d;
  logic [RK_IDX_W-1:0] rd_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      blk_q   <= '0;
      enc_q   <= 1'b0;
      tag_q   <= '0;
      tmo_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      blk_q   <= blk_d;
      enc_q   <= enc_d;
      tag_q   <= tag_d;
      tmo_q   <= tmo_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    blk_d   = blk_q;
    enc_d   = enc_q;
    tag_d   = tag_q;
    tmo_d   = tmo_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        beat_d = '0;
        tmo_d  = '0;
        if (in_valid) begin
          blk_d   = in_block;
          enc_d   = in_enc_dec;
          tag_d   = in_tag;
          state_d = StLoad;
        end
      end
      StLoad: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == BEAT_LAST) begin
          state_d = StRel;
        end
      end
      StRel:   state_d = StStart;
      StStart: state_d = StRun;
      StRun: begin
        tmo_d = tmo_q + 1'b1;
        // Completion wins over a timeout landing in the same cycle.
        if (core_done) begin
          res_d   = core_state_out;
          err_d   = 1'b0;
          state_d = StOut;
        end else if (tmo_q == TMO_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Decrypt walks the schedule backwards; any out-of-range round reads the last key.
  always_comb begin
    rd_idx = '0;
    if (state_q == StRun) begin
      if (core_round > LAST_IDX) begin
        rd_idx = LAST_IDX;
      end else if (enc_q) begin
        rd_idx = core_round;
      end else begin
        rd_idx = LAST_IDX - core_round;
      end
    end
  end

  aes_pnm_rk_table #(
    .N_ROUNDS (N_ROUNDS)
  ) u_rk_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_allow_i (state_q == StIdle),
    .wr_en_i    (rk_wr_en),
    .wr_idx_i   (rk_wr_idx),
    .wr_data_i  (rk_wr_data),
    .rd_idx_i   (rd_idx),
    .rd_data_o  (core_key),
    .wr_drop_o  (rk_wr_drop)
  );

  assign in_ready           = (state_q == StIdle);
  assign busy               = (state_q != StIdle);
  assign core_state_init_en = (state_q == StLoad);
  assign core_state_init    = blk_q;
  assign core_start         = (state_q == StStart);
  assign core_enc_dec       = (state_q != StIdle) && enc_q;
  assign out_valid          = (state_q == StOut);
  assign out_block          = res_q;
  assign out_tag            = tag_q;
  assign out_err            = err_q;

endmodule

// File: tb/tb_aes_pnm_job_sched.sv
// Self-checking bench: a round-folding core stub driven by the scheduler's key output,
// with expected results derived from a plain key-schedule model of the indexing rules.
module tb_aes_pnm_job_sched;

  localparam int unsigned NR  = 10;
  localparam int unsigned TW  = 4;
  localparam int unsigned TMO = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, in_enc_dec;
  logic [127:0]  in_block;
  logic [TW-1:0] in_tag;
  logic          rk_wr_en, rk_wr_drop;
  logic [3:0]    rk_wr_idx;
  logic [127:0]  rk_wr_data;
  logic          core_start, core_enc_dec, core_state_init_en, core_done;
  logic [127:0]  core_state_init, core_key, core_state_out;
  logic [3:0]    core_round;
  logic          out_valid, out_ready, out_err, busy;
  logic [127:0]  out_block;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  aes_pnm_job_sched #(
    .N_ROUNDS    (NR),
    .TAG_W       (TW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_block           (in_block),
    .in_enc_dec         (in_enc_dec),
    .in_tag             (in_tag),
    .rk_wr_en           (rk_wr_en),
    .rk_wr_idx          (rk_wr_idx),
    .rk_wr_data         (rk_wr_data),
    .rk_wr_drop         (rk_wr_drop),
    .core_start         (core_start),
    .core_enc_dec       (core_enc_dec),
    .core_state_init    (core_state_init),
    .core_state_init_en (core_state_init_en),
    .core_key           (core_key),
    .core_done          (core_done),
    .core_round         (core_round),
    .core_state_out     (core_state_out),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_block          (out_block),
    .out_tag            (out_tag),
    .out_err            (out_err),
    .busy               (busy)
  );

  // Core stub: each round folds the presented key into a rotating accumulator.
  logic         stub_hang, spur_done, stub_done, stub_run;
  logic [3:0]   hang_round, stub_r;
  logic [127:0] stub_init, stub_acc, stub_nxt;
  logic [127:0] seen_key [16];

  assign stub_nxt   = {stub_acc[126:0], stub_acc[127]} ^ core_key;
  assign core_round = stub_hang ? hang_round : stub_r;
  assign core_done  = stub_done | spur_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_run       <= 1'b0;
      stub_r         <= '0;
      stub_done      <= 1'b0;
      stub_acc       <= '0;
      stub_init      <= '0;
      core_state_out <= '0;
    end else begin
      stub_done <= 1'b0;
      if (core_state_init_en) stub_init <= core_state_init;
      if (core_start) begin
        stub_run <= 1'b1;
        stub_r   <= '0;
        stub_acc <= stub_init;
      end else if (stub_hang) begin
        stub_run <= 1'b0;
      end else if (stub_run) begin
        seen_key[stub_r] <= core_key;
        stub_acc         <= stub_nxt;
        if (stub_r == 4'(NR)) begin
          stub_run       <= 1'b0;
          stub_done      <= 1'b1;
          core_state_out <= stub_nxt;
        end else begin
          stub_r <= stub_r + 4'd1;
        end
      end
    end
  end

  // Reference key schedule and result model.
  logic [127:0] rk_m [16];
  int n_chk = 0;
  int n_err = 0;

  function automatic logic [127:0] ref_result(input logic [127:0] blk, input logic enc);
    logic [127:0] acc;
    acc = blk;
    for (int r = 0; r <= int'(NR); r++) begin
      acc = {acc[126:0], acc[127]} ^ rk_m[enc ? r : int'(NR) - r];
    end
    return acc;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input logic [3:0] idx, input logic [127:0] d, input bit exp_drop);
    rk_wr_en = 1'b1; rk_wr_idx = idx; rk_wr_data = d;
    tick();
    rk_wr_en = 1'b0;
    chk("rk_wr_drop", 128'(rk_wr_drop), 128'(exp_drop));
    if (!exp_drop) rk_m[idx] = d;
  endtask

  task automatic chk_reset_outputs(input bit key_known);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_ctl", 128'({rk_wr_drop, core_start, core_enc_dec, core_state_init_en, out_valid,
                         out_tag, out_err, busy}), 128'd0);
    chk("rst_init", core_state_init, 128'd0);
    chk("rst_out_block", out_block, 128'd0);
    if (key_known) chk("rst_key_idx0", core_key, rk_m[0]);
  endtask

  // Accepts a job and checks the init/release/start timing; returns at the first RUN cycle.
  task automatic submit(input logic [127:0] blk, input logic enc, input logic [TW-1:0] tag,
                        input bit wr, input logic [3:0] widx, input logic [127:0] wdat);
    int   w = 0;
    logic [5:0] obs_init, obs_start;
    bit   init_ok = 1'b1;
    while (!in_ready && w < 100) begin tick(); w++; end
    chk("in_ready_wait", 128'(in_ready), 128'd1);
    in_valid = 1'b1; in_block = blk; in_enc_dec = enc; in_tag = tag;
    if (wr) begin rk_wr_en = 1'b1; rk_wr_idx = widx; rk_wr_data = wdat; end
    tick();
    in_valid = 1'b0; rk_wr_en = 1'b0; in_block = ~blk; in_enc_dec = ~enc; in_tag = ~tag;
    if (wr) begin
      chk("wr_at_accept_drop", 128'(rk_wr_drop), 128'd0);
      rk_m[widx] = wdat;
    end
    for (int i = 0; i < 6; i++) begin
      obs_init[i]  = core_state_init_en;
      obs_start[i] = core_start;
      if (i < 4 && core_state_init !== blk) init_ok = 1'b0;
      tick();
    end
    chk("init_en_seq", 128'(obs_init), 128'(6'b001111));
    chk("start_seq", 128'(obs_start), 128'(6'b100000));
    chk("init_data", 128'(init_ok), 128'd1);
    chk("core_enc_dec", 128'(core_enc_dec), 128'(enc));
  endtask

  task automatic finish(input logic [127:0] eb, input logic [TW-1:0] et, input logic ee,
                        input int stall, input int cyc0);
    int cyc = cyc0;
    bit prev_done = 1'b0;
    bit stable = 1'b1;
    bit rdy_low = 1'b1;
    logic [127:0] hb; logic [TW-1:0] ht; logic he;
    while (!out_valid && cyc < 3000) begin prev_done = core_done; tick(); cyc++; end
    chk("out_valid_seen", 128'(out_valid), 128'd1);
    if (ee) chk("timeout_cycles", 128'(cyc), 128'(TMO));
    else    chk("done_to_valid", 128'(prev_done), 128'd1);
    hb = out_block; ht = out_tag; he = out_err;
    if (in_ready) rdy_low = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      if (!out_valid || out_block !== hb || out_tag !== ht || out_err !== he) stable = 1'b0;
      if (in_ready) rdy_low = 1'b0;
    end
    chk("out_hold_stable", 128'(stable), 128'd1);
    chk("in_ready_low_in_out", 128'(rdy_low), 128'd1);
    chk("out_block", out_block, eb);
    chk("out_tag", 128'(out_tag), 128'(et));
    chk("out_err", 128'(out_err), 128'(ee));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_handshake", 128'({out_valid, in_ready}), 128'(2'b01));
  endtask

  typedef struct {
    logic [127:0]  blk;
    logic          enc;
    logic [TW-1:0] tag;
    int            stall;
    logic [127:0]  exp_blk;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [127:0] init_keys [11];
    logic [127:0] blk, eb;
    logic         enc;
    logic [TW-1:0] tag;
    bit           saw_valid;
    in_valid = 0; in_block = '0; in_enc_dec = 0; in_tag = '0; out_ready = 0;
    rk_wr_en = 0; rk_wr_idx = '0; rk_wr_data = '0;
    stub_hang = 0; spur_done = 0; hang_round = '0;

    #12;
    chk_reset_outputs(1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    init_keys[0]  = 128'h000102030405060708090a0b0c0d0e0f;
    init_keys[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    for (int i = 1; i < 10; i++) init_keys[i] = rnd128();
    for (int i = 0; i <= int'(NR); i++) wr_key(4'(i), init_keys[i], 1'b0);
    wr_key(4'd12, rnd128(), 1'b1);
    tick();
    chk("drop_is_pulse", 128'(rk_wr_drop), 128'd0);

    spur_done = 1'b1; tick(); spur_done = 1'b0; tick();
    chk("spurious_done", 128'({out_valid, in_ready, busy}), 128'(3'b010));

    vecs[0] = '{128'h00112233445566778899aabbccddeeff, 1'b1, 4'd3, 0, '0};
    vecs[1] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 4'd9, 1, '0};
    vecs[2] = '{128'hffffffffffffffffffffffffffffffff, 1'b1, 4'd15, 7, '0};
    vecs[3] = '{128'h0, 1'b0, 4'd0, 2, '0};
    for (int i = 0; i < 4; i++) vecs[i].exp_blk = ref_result(vecs[i].blk, vecs[i].enc);

    for (int i = 0; i < 4; i++) begin
      submit(vecs[i].blk, vecs[i].enc, vecs[i].tag, 1'b0, '0, '0);
      finish(vecs[i].exp_blk, vecs[i].tag, 1'b0, vecs[i].stall, 0);
      chk("key_at_round0", seen_key[0], rk_m[vecs[i].enc ? 0 : NR]);
      chk("key_at_roundN", seen_key[NR], rk_m[vecs[i].enc ? NR : 0]);
    end

    // Stuck core: key clamping, busy-time write drop, then timeout.
    stub_hang = 1'b1; hang_round = 4'd3;
    submit(rnd128(), 1'b1, 4'd6, 1'b0, '0, '0);
    chk("key_enc_round3", core_key, rk_m[3]);
    hang_round = 4'd15; #1;
    chk("key_clamp", core_key, rk_m[NR]);
    rk_wr_en = 1'b1; rk_wr_idx = 4'd5; rk_wr_data = ~rk_m[5];
    tick();
    rk_wr_en = 1'b0;
    chk("drop_in_run", 128'(rk_wr_drop), 128'd1);
    hang_round = 4'd5; #1;
    chk("key5_unchanged", core_key, rk_m[5]);
    tick();
    chk("drop_in_run_pulse", 128'(rk_wr_drop), 128'd0);
    finish(128'd0, 4'd6, 1'b1, 2, 2);
    stub_hang = 1'b0;

    blk = rnd128();
    submit(blk, 1'b1, 4'd7, 1'b0, '0, '0);
    finish(ref_result(blk, 1'b1), 4'd7, 1'b0, 0, 0);

    // Reset in the middle of a run aborts silently.
    submit(rnd128(), 1'b0, 4'd2, 1'b0, '0, '0);
    tick(); tick();
    rst_n = 1'b0; #1;
    chk_reset_outputs(1'b1);
    tick();
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin tick(); if (out_valid) saw_valid = 1'b1; end
    chk("no_valid_after_reset", 128'(saw_valid), 128'd0);
    blk = rnd128();
    submit(blk, 1'b0, 4'd11, 1'b0, '0, '0);
    finish(ref_result(blk, 1'b0), 4'd11, 1'b0, 1, 0);

    for (int j = 0; j < 8; j++) begin
      logic [3:0] widx;
      bit wr;
      if ($urandom_range(0, 1) == 1) wr_key(4'($urandom_range(0, NR)), rnd128(), 1'b0);
      blk = rnd128();
      enc = 1'($urandom_range(0, 1));
      tag = TW'($urandom);
      wr = 1'($urandom_range(0, 1));
      widx = 4'($urandom_range(0, NR));
      submit(blk, enc, tag, wr, widx, rnd128());
      eb = ref_result(blk, enc);
      finish(eb, tag, 1'b0, $urandom_range(0, 3), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_pnm_job_sched.md
Name: aes_pnm_job_sched

Overview:
- Job-level scheduler in front of the FeRAM near-memory AES core.
- Accepts 128-bit blocks over a valid/ready handshake and stores the expanded round-key schedule.
- Drives the core through its sequence: 4-cycle state-init load, one release cycle, start pulse, then per-round key selection while running.
- Captures the result on done and returns it over a valid/ready output handshake, with a timeout watchdog.

Parameters:
- N_ROUNDS, 10: AES rounds; round-key table holds N_ROUNDS+1 entries.
- TAG_W, 4: width of the job tag carried from input to output.
- TIMEOUT_CYC, 1023: maximum RUN-state cycles before a job is aborted; counter width is clog2(TIMEOUT_CYC+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  job request
- in_ready  out  1  scheduler can accept a job
- in_block  in  128  plaintext or ciphertext block
- in_enc_dec  in  1  1 = encrypt, 0 = decrypt
- in_tag  in  TAG_W  job tag
- rk_wr_en  in  1  round-key table write
- rk_wr_idx  in  4  round-key index, 0..N_ROUNDS
- rk_wr_data  in  128  round key; byte [8*(4r+c)+:8] = key_rc
- rk_wr_drop  out  1  one-cycle pulse: write ignored (busy or index > N_ROUNDS)
- core_start  out  1  start pulse to core
- core_enc_dec  out  1  mode to core
- core_state_init  out  128  block to core
- core_state_init_en  out  1  core init-load enable
- core_key  out  128  current round key, same byte layout as rk_wr_data
- core_done  in  1  core completion
- core_round  in  4  core round counter
- core_state_out  in  128  core result
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_block  out  128  result block
- out_tag  out  TAG_W  tag of the finished job
- out_err  out  1  1 = job aborted by timeout; out_block is then 0
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous: FSM to IDLE. in_ready=1 is the only output set to 1. All other outputs, the job registers and the timeout counter are 0. The round-key table is not reset and reads as X until written. Reset mid-job aborts the job silently; no out_valid is produced.
- IDLE: in_ready=1. When in_valid&in_ready, latch block, enc_dec and tag, then go to LOAD.
- LOAD: 4 cycles. core_state_init_en=1 and core_state_init=latched block, both held stable; a 2-bit counter counts 0..3.
- REL: 1 cycle. core_state_init_en=0 so the core's init-done flag clears.
- START: 1 cycle. core_start=1.
- RUN: wait for core_done.
  - core_key is driven combinationally from the table at index core_round when enc_dec=1, and at index N_ROUNDS-core_round when enc_dec=0.
  - Index clamps to N_ROUNDS if core_round > N_ROUNDS.
  - Outside RUN, core_key is the index 0 entry.
  - The timeout counter increments each RUN cycle.
  - If core_done is high, capture core_state_out, set out_err=0, go to OUT. core_done takes priority over the timeout in the same cycle.
  - Else if the counter reaches TIMEOUT_CYC, set out_block=0 and out_err=1, go to OUT.
- OUT: out_valid=1. out_block, out_tag and out_err are held stable until out_valid&out_ready. On that handshake, clear out_valid and return to IDLE; in_ready rises the next cycle. A new job cannot overlap the output handshake.
- Latency: accept at cycle T gives init_en high T+1..T+4, low at T+5, core_start at T+6. With done at cycle D, out_valid rises at D+1; zero-stall output adds no further cycles.
- core_enc_dec is driven from the latched mode from LOAD through OUT and is 0 in IDLE.
- Round-key writes:
  - Accepted only in IDLE with rk_wr_idx <= N_ROUNDS; the write lands the next cycle.
  - A write in the same cycle as job acceptance is still applied, because it occurs in IDLE.
  - Otherwise the write is dropped and rk_wr_drop pulses one cycle.
- A spurious core_done outside RUN is ignored.

Decomposition:
- Shared package aes_pnm_pkg:
  - FSM state enum: IDLE, LOAD, REL, START, RUN, OUT.
  - Constants: INIT_BEATS=4, key byte-index function.
- One natural sub-module: aes_pnm_rk_table, a flop array of (N_ROUNDS+1)x128 with one write port and one combinational read port, plus the drop-check logic.
- The FSM, counters and handshake live in the top.

Test Plan:
- Key loading and timing: load FIPS-197 key schedule (rk0=000102..0f, rk10=13111d7fe3944a17f307a78b4d2b30c5), submit enc job 00112233445566778899aabbccddeeff tag 3 with core model attached -> init_en high exactly 4 cycles, low 1, start at T+6, out_block=69c4e0d86a7b0430d8cdb78070b4c55a, out_tag=3, out_err=0.
- Decrypt key indexing: decrypt of 69c4e0d86a7b0430d8cdb78070b4c55a -> core_key at core_round=0 equals rk10 and at core_round=10 equals rk0; output 00112233445566778899aabbccddeeff.
- Timeout: core stub never asserts done, TIMEOUT_CYC=20 -> out_valid after 20 RUN cycles, out_err=1, out_block=0; next job proceeds normally.
- Output backpressure: out_ready low 7 cycles -> out_valid and out_block held stable, in_ready=0 throughout; in_ready=1 the cycle after the handshake.
- Dropped key writes: rk_wr_en with idx=5 during RUN, and idx=12 in IDLE -> rk_wr_drop pulses each time, table unchanged (read back via core_key).
- Reset mid-RUN: assert rst_n=0 during RUN -> all outputs 0 except in_ready=1, no out_valid; a fresh job then completes correctly.
